neo_refresh_sequencer: RTL and testbench

Sits between ch9329_HID_receiver and ws2812b_controller, replacing the free-running refresh counter in the top level. Captures each newly received R/G/B byte triple and presents stable colour words to the NeoPixel controller. Issues a start_n frame request only when the colour changes or an optional periodic refresh timer expires. Enforces a minimum frame spacing so a new request never interrupts a frame in flight.

---
 rtl/neo_refresh_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_neo_refresh_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_refresh_sequencer.sv
// -----------------------------------------------------------------------------
// neo_refresh_sequencer
//
// Captures R/G/B byte triples from the HID receiver and presents stable colour
// words to the WS2812B controller. A frame request (start_n low pulse) is
// issued only when a new colour has been captured or, if enabled, when the
// periodic refresh timer expires. Frames are spaced so that a new request can
// never interrupt a frame that is still being shifted out or latched.
//
// Optional build macro: NEO_FADE_EN
//   Defined   : each LOAD moves every displayed channel one step toward the
//               target; the sequencer keeps requesting frames until the
//               displayed colour reaches the target.
//   Undefined : each LOAD copies the target directly.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   data_valid  in   receiver valid flag; only its rising edge is used
//   data_byte1  in   red byte
//   data_byte2  in   green byte
//   data_byte3  in   blue byte
//   rgb_data_0  out  LED0 colour {R, G, B}
//   rgb_data_1  out  LED1 colour {R, G, B}
//   start_n     out  active-low frame request
//   busy        out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module neo_refresh_sequencer #(
    parameter int unsigned SYS_FREQ         = 12_090_000,
    parameter int unsigned START_LOW_CYCLES = 4,
    parameter int unsigned FRAME_CYCLES     = 1400,
    parameter int unsigned REFRESH_CYCLES   = 0,
    parameter int unsigned MIRROR           = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [7:0]  data_byte1,
    input  logic [7:0]  data_byte2,
    input  logic [7:0]  data_byte3,
    output logic [23:0] rgb_data_0,
    output logic [23:0] rgb_data_1,
    output logic        start_n,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for a captured colour or refresh timer expiry
    // LOAD   | one cycle: update displayed colours, consume pending
    // START  | start_n held low for START_LOW_CYCLES cycles
    // HOLD   | start_n high for FRAME_CYCLES cycles while the frame completes
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [7:0]  START_LOAD   = 8'(START_LOW_CYCLES - 1);
    localparam logic [15:0] FRAME_LOAD   = 16'(FRAME_CYCLES - 1);
    localparam bit          REFRESH_EN   = (REFRESH_CYCLES != 0);
    localparam logic [23:0] REFRESH_LAST = REFRESH_EN ? 24'(REFRESH_CYCLES - 1) : 24'd0;

    if (SYS_FREQ == 0 || START_LOW_CYCLES < 1 || START_LOW_CYCLES > 255 ||
        FRAME_CYCLES < 2 || FRAME_CYCLES > 65535 ||
        REFRESH_CYCLES > 32'h00FF_FFFF || MIRROR > 1) begin : g_bad_params
        $error("neo_refresh_sequencer: parameter out of range");
    end

    logic [1:0]  state_q,       state_d;
    logic        dv_q;
    logic        pending_q,     pending_d;
    logic [23:0] target_q,      target_d;
    logic [23:0] rgb0_q,        rgb0_d;
    logic [23:0] rgb1_q,        rgb1_d;
    logic [7:0]  start_cnt_q,   start_cnt_d;
    logic [15:0] frame_cnt_q,   frame_cnt_d;
    logic [23:0] refresh_cnt_q, refresh_cnt_d;

    logic cap_edge;
    logic refresh_hit;

    assign cap_edge    = data_valid & ~dv_q;
    assign refresh_hit = REFRESH_EN && (refresh_cnt_q == REFRESH_LAST);

`ifdef NEO_FADE_EN
    // Set by a capture, cleared by the next LOAD: marks the first fade step
    // of a new target so the two-LED history chain shifts only once.
    logic        new_tgt_q, new_tgt_d;
    logic [23:0] rgb_step;

    function automatic logic [7:0] fade_ch(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      fade_ch = cur + 8'd1;
        else if (cur > tgt) fade_ch = cur - 8'd1;
        else                fade_ch = cur;
    endfunction

    assign rgb_step = {fade_ch(rgb0_q[23:16], target_q[23:16]),
                       fade_ch(rgb0_q[15:8],  target_q[15:8]),
                       fade_ch(rgb0_q[7:0],   target_q[7:0])};
`endif

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        target_d      = target_q;
        rgb0_d        = rgb0_q;
        rgb1_d        = rgb1_q;
        start_cnt_d   = start_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        refresh_cnt_d = refresh_cnt_q;
`ifdef NEO_FADE_EN
        new_tgt_d     = new_tgt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A capture in this very cycle also triggers LOAD so the new
                // colour is loaded one cycle after its valid edge.
                if (pending_q || cap_edge || refresh_hit) begin
                    state_d       = S_LOAD;
                    refresh_cnt_d = 24'd0;
                end else if (REFRESH_EN && (refresh_cnt_q != REFRESH_LAST)) begin
                    refresh_cnt_d = refresh_cnt_q + 24'd1;
                end
            end
            S_LOAD: begin
                pending_d = 1'b0;
`ifdef NEO_FADE_EN
                rgb0_d = rgb_step;
                if (rgb_step != target_q) pending_d = 1'b1;
                if (MIRROR != 0)   rgb1_d = rgb_step;
                else if (new_tgt_q) rgb1_d = rgb0_q;
                new_tgt_d = 1'b0;
`else
                rgb0_d = target_q;
                if (MIRROR != 0)   rgb1_d = target_q;
                else if (pending_q) rgb1_d = rgb0_q;   // refresh-only loads keep history
`endif
                start_cnt_d = START_LOAD;
                state_d     = S_START;
            end
            S_START: begin
                if (start_cnt_q == 8'd0) begin
                    frame_cnt_d = FRAME_LOAD;
                    state_d     = S_HOLD;
                end else begin
                    start_cnt_d = start_cnt_q - 8'd1;
                end
            end
            default: begin
                if (frame_cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    frame_cnt_d = frame_cnt_q - 16'd1;
                end
            end
        endcase

        // Captures win over the LOAD clear, so a colour arriving during LOAD
        // still gets its own frame.
        if (cap_edge) begin
            target_d  = {data_byte1, data_byte2, data_byte3};
            pending_d = 1'b1;
`ifdef NEO_FADE_EN
            new_tgt_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            dv_q          <= 1'b0;
            pending_q     <= 1'b0;
            target_q      <= 24'd0;
            rgb0_q        <= 24'd0;
            rgb1_q        <= 24'd0;
            start_cnt_q   <= 8'd0;
            frame_cnt_q   <= 16'd0;
            refresh_cnt_q <= 24'd0;
`ifdef NEO_FADE_EN
            new_tgt_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            dv_q          <= data_valid;
            pending_q     <= pending_d;
            target_q      <= target_d;
            rgb0_q        <= rgb0_d;
            rgb1_q        <= rgb1_d;
            start_cnt_q   <= start_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            refresh_cnt_q <= refresh_cnt_d;
`ifdef NEO_FADE_EN
            new_tgt_q     <= new_tgt_d;
`endif
        end
    end

    // Decoded from state so reset releases start_n asynchronously.
    assign start_n    = (state_q != S_START);
    assign busy       = (state_q != S_IDLE);
    assign rgb_data_0 = rgb0_q;
    assign rgb_data_1 = rgb1_q;

endmodule

// File: tb/tb_neo_refresh_sequencer.sv
module tb_neo_refresh_sequencer;

    localparam int START_LOW = 4;
    localparam int FRAME     = 20;
    localparam int REFRESH_B = 50;
    localparam int PERIOD_B  = REFRESH_B + 1 + START_LOW + FRAME;

    typedef struct {
        logic [23:0] r0;
        logic [23:0] r1;
        int          fall;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int errors = 0;

    // u_a: mirror, no refresh
    logic        rst_a_n, dv_a, start_n_a, busy_a;
    logic [7:0]  b1_a, b2_a, b3_a;
    logic [23:0] rgb0_a, rgb1_a;
    // u_b: mirror, periodic refresh, no input
    logic        rst_b_n, start_n_b, busy_b;
    logic [23:0] rgb0_b, rgb1_b;
    // u_c: history chain, no refresh
    logic        rst_c_n, dv_c, start_n_c, busy_c;
    logic [7:0]  b1_c, b2_c, b3_c;
    logic [23:0] rgb0_c, rgb1_c;

    neo_refresh_sequencer #(.SYS_FREQ(12_090_000), .START_LOW_CYCLES(START_LOW),
        .FRAME_CYCLES(FRAME), .REFRESH_CYCLES(0), .MIRROR(1)) u_a (
        .clk(clk), .rst_n(rst_a_n), .data_valid(dv_a),
        .data_byte1(b1_a), .data_byte2(b2_a), .data_byte3(b3_a),
        .rgb_data_0(rgb0_a), .rgb_data_1(rgb1_a), .start_n(start_n_a), .busy(busy_a));

    neo_refresh_sequencer #(.SYS_FREQ(12_090_000), .START_LOW_CYCLES(START_LOW),
        .FRAME_CYCLES(FRAME), .REFRESH_CYCLES(REFRESH_B), .MIRROR(1)) u_b (
        .clk(clk), .rst_n(rst_b_n), .data_valid(1'b0),
        .data_byte1(8'h00), .data_byte2(8'h00), .data_byte3(8'h00),
        .rgb_data_0(rgb0_b), .rgb_data_1(rgb1_b), .start_n(start_n_b), .busy(busy_b));

    neo_refresh_sequencer #(.SYS_FREQ(12_090_000), .START_LOW_CYCLES(START_LOW),
        .FRAME_CYCLES(FRAME), .REFRESH_CYCLES(0), .MIRROR(0)) u_c (
        .clk(clk), .rst_n(rst_c_n), .data_valid(dv_c),
        .data_byte1(b1_c), .data_byte2(b2_c), .data_byte3(b3_c),
        .rgb_data_0(rgb0_c), .rgb_data_1(rgb1_c), .start_n(start_n_c), .busy(busy_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    frame_t exp_a[$];
    frame_t exp_c[$];

    task automatic push_a(input logic [23:0] r0, input logic [23:0] r1, input int fall);
        frame_t f;
        f.r0 = r0; f.r1 = r1; f.fall = fall;
        exp_a.push_back(f);
    endtask

    task automatic push_c(input logic [23:0] r0, input logic [23:0] r1, input int fall);
        frame_t f;
        f.r0 = r0; f.r1 = r1; f.fall = fall;
        exp_c.push_back(f);
    endtask

    // ---------------- monitor A ----------------
    logic        prev_sn_a = 1'b1;
    bit          in_a      = 1'b0;
    int          low_a     = 0;
    int          falls_a   = 0;
    logic [23:0] held0_a, held1_a;
    always @(negedge clk) begin
        frame_t f;
        if (!rst_a_n) begin
            prev_sn_a = 1'b1;
            in_a      = 1'b0;
        end else begin
            if (prev_sn_a && !start_n_a) begin
                falls_a++;
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_frame actual=%0h required=no_frame", rgb0_a);
                end else begin
                    f = exp_a.pop_front();
                    check("a_rgb0", rgb0_a, f.r0);
                    check("a_rgb1", rgb1_a, f.r1);
                    check("a_fall_cycle", cyc_cnt, f.fall);
                end
                held0_a = rgb0_a; held1_a = rgb1_a;
                in_a = 1'b1; low_a = 1;
            end else if (!start_n_a) begin
                low_a++;
            end else if (in_a && !prev_sn_a) begin
                check("a_low_len", low_a, START_LOW);
                check("a_rgb0_stable", rgb0_a, held0_a);
                check("a_rgb1_stable", rgb1_a, held1_a);
                in_a = 1'b0;
            end
            prev_sn_a = start_n_a;
        end
    end

    // ---------------- monitor B ----------------
    logic prev_sn_b = 1'b1;
    int   falls_b = 0, last_fall_b = 0, first_b_exp = 0;
    always @(negedge clk) begin
        if (!rst_b_n) begin
            prev_sn_b = 1'b1;
        end else begin
            if (prev_sn_b && !start_n_b) begin
                if (falls_b == 0) check("b_first_fall_cycle", cyc_cnt, first_b_exp);
                else              check("b_refresh_period", cyc_cnt - last_fall_b, PERIOD_B);
                check("b_rgb0_unchanged", rgb0_b, 24'h0);
                check("b_rgb1_unchanged", rgb1_b, 24'h0);
                last_fall_b = cyc_cnt;
                falls_b++;
            end
            prev_sn_b = start_n_b;
        end
    end

    // ---------------- monitor C ----------------
    logic prev_sn_c = 1'b1;
    always @(negedge clk) begin
        frame_t f;
        if (!rst_c_n) begin
            prev_sn_c = 1'b1;
        end else begin
            if (prev_sn_c && !start_n_c) begin
                if (exp_c.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL c_unexpected_frame actual=%0h required=no_frame", rgb0_c);
                end else begin
                    f = exp_c.pop_front();
                    check("c_rgb0", rgb0_c, f.r0);
                    check("c_rgb1", rgb1_c, f.r1);
                    check("c_fall_cycle", cyc_cnt, f.fall);
                end
            end
            prev_sn_c = start_n_c;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        b1_a = r; b2_a = g; b3_a = b; dv_a = 1'b1;
        cyc();
        dv_a = 1'b0;
    endtask

    task automatic pulse_c(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        b1_c = r; b2_c = g; b3_c = b; dv_c = 1'b1;
        cyc();
        dv_c = 1'b0;
    endtask

    initial begin
        int n;
        int c0;
        int f0;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        dv_a = 1'b0; b1_a = 8'h00; b2_a = 8'h00; b3_a = 8'h00;
        dv_c = 1'b0; b1_c = 8'h00; b2_c = 8'h00; b3_c = 8'h00;
        repeat (3) cyc();

        check("rst_rgb0", rgb0_a, 24'h0);
        check("rst_rgb1", rgb1_a, 24'h0);
        check("rst_start_n", start_n_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_b_start_n", start_n_b, 1'b1);

        rst_a_n = 1'b1; rst_c_n = 1'b1;
        rst_b_n = 1'b1; first_b_exp = cyc_cnt + REFRESH_B + 1;
        cyc(); cyc();

        // single capture: latency and busy duration
        push_a(24'h123456, 24'h123456, cyc_cnt + 2);
        pulse_a(8'h12, 8'h34, 8'h56);
        check("t1_busy_in_load", busy_a, 1'b1);
        check("t1_rgb_before_load", rgb0_a, 24'h0);
        n = 0;
        while (busy_a && n < 200) begin cyc(); n++; end
        check("t1_busy_cycles", n, 1 + START_LOW + FRAME);
        repeat (10) cyc();

        // three captures during HOLD collapse into one frame with the last value
        c0 = cyc_cnt;
        push_a(24'h202020, 24'h202020, c0 + 2);
        pulse_a(8'h20, 8'h20, 8'h20);
        repeat (7) cyc();
        push_a(24'h0A0B0C, 24'h0A0B0C, c0 + 28);
        pulse_a(8'h01, 8'h02, 8'h03);
        cyc();
        pulse_a(8'h04, 8'h05, 8'h06);
        cyc();
        pulse_a(8'h0A, 8'h0B, 8'h0C);
        repeat (60) cyc();
        check("t2_idle", busy_a, 1'b0);

        // capture coinciding with LOAD
        c0 = cyc_cnt;
        push_a(24'h303030, 24'h303030, c0 + 2);
        push_a(24'h404040, 24'h404040, c0 + 28);
        push_a(24'h505050, 24'h505050, c0 + 54);
        pulse_a(8'h30, 8'h30, 8'h30);
        repeat (9) cyc();
        pulse_a(8'h40, 8'h40, 8'h40);
        repeat (15) cyc();
        check("t3_idle_gap", busy_a, 1'b0);
        cyc();
        check("t3_load_cycle", busy_a, 1'b1);
        pulse_a(8'h50, 8'h50, 8'h50);
        repeat (60) cyc();

        // no refresh configured: no frames while idle
        f0 = falls_a;
        repeat (10000) cyc();
        check("t4_no_refresh_frames", falls_a - f0, 0);

        // reset during START
        push_a(24'h778899, 24'h778899, cyc_cnt + 2);
        pulse_a(8'h77, 8'h88, 8'h99);
        cyc(); cyc();
        rst_a_n = 1'b0;
        #1;
        check("t6_rst_start_n", start_n_a, 1'b1);
        check("t6_rst_rgb0", rgb0_a, 24'h0);
        check("t6_rst_rgb1", rgb1_a, 24'h0);
        check("t6_rst_busy", busy_a, 1'b0);
        repeat (3) cyc();
        rst_a_n = 1'b1;
        cyc();
        push_a(24'hA1B2C3, 24'hA1B2C3, cyc_cnt + 2);
        pulse_a(8'hA1, 8'hB2, 8'hC3);
        repeat (40) cyc();

        // history chain
        push_c(24'hFF0000, 24'h000000, cyc_cnt + 2);
        pulse_c(8'hFF, 8'h00, 8'h00);
        repeat (40) cyc();
        push_c(24'h00FF00, 24'hFF0000, cyc_cnt + 2);
        pulse_c(8'h00, 8'hFF, 8'h00);
        repeat (40) cyc();
        check("t5_rgb0_final", rgb0_c, 24'h00FF00);
        check("t5_rgb1_final", rgb1_c, 24'hFF0000);

        check("a_missing_frames", exp_a.size(), 0);
        check("c_missing_frames", exp_c.size(), 0);
        check("b_refresh_active", falls_b >= 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
